// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage with PC, imem handshake, IR and next-PC.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             Zero,
    input  logic             pcW,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       func,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [15:0]      imm16,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  w_state_nxt = c_FETCH;
            c_FETCH: if (imem_ready) w_state_nxt = c_EXEC;
            c_EXEC:  if (pcW) w_state_nxt = c_FETCH;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (r_state == c_FETCH);
    end

    // Jump takes priority over a taken branch if control asserts both.
    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        if (Jump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (Branch && Zero) begin
            w_next_pc = w_pc_plus4 + w_br_off;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= {RESET_PC[31:2], 2'b00};
            r_instr   <= 32'd0;
            r_valid   <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                    end
                end
                c_EXEC: begin
                    if (pcW) begin
                        r_pc      <= {w_next_pc[31:2], 2'b00};
                        r_retired <= r_retired + CNT_W'(1);
                        r_valid   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign retired     = r_retired;
    assign op          = r_instr[31:26];
    assign func        = r_instr[5:0];
    assign rs          = r_instr[25:21];
    assign rt          = r_instr[20:16];
    assign rd          = r_instr[15:11];
    assign imm16       = r_instr[15:0];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        Branch, Jump, Zero, pcW;
    logic [31:0] instr;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic        instr_valid;
    logic [31:0] pc, pc_plus4;
    logic [31:0] retired;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(c_RESET_PC), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .pcW(pcW),
        .instr(instr), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .imm16(imm16), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ctl();
        Branch = 1'($urandom);
        Jump   = 1'($urandom);
        Zero   = 1'($urandom);
    endtask

    // Reference next-PC computed arithmetically from the committed word.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input bit br, input bit jmp, input bit z);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        off = int'($signed(w[15:0])) * 4;
        if (jmp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (br && z) return seq + 32'(off);
        return seq;
    endfunction

    // One instruction: optional wait states, delivery, optional stalls, commit.
    task automatic run_instr(input logic [31:0] word, input int waits, input int holds,
                             input bit br, input bit jmp, input bit z);
        chk("req_fetch", 32'(imem_req), 32'd1);
        chk("addr", imem_addr, m_pc);
        chk("valid_fetch", 32'(instr_valid), 32'd0);
        imem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            pcW = 1'($urandom);
            rand_ctl();
            tick();
            chk("req_wait", 32'(imem_req), 32'd1);
            chk("addr_wait", imem_addr, m_pc);
            chk("valid_wait", 32'(instr_valid), 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        pcW        = 1'($urandom);
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("valid_exec", 32'(instr_valid), 32'd1);
        chk("req_exec", 32'(imem_req), 32'd0);
        chk("instr", instr, word);
        chk("op", 32'(op), word >> 26);
        chk("func", 32'(func), word & 32'h3F);
        chk("rs", 32'(rs), (word >> 21) & 32'h1F);
        chk("rt", 32'(rt), (word >> 16) & 32'h1F);
        chk("rd", 32'(rd), (word >> 11) & 32'h1F);
        chk("imm16", 32'(imm16), word & 32'hFFFF);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        pcW = 1'b0;
        for (int i = 0; i < holds; i++) begin
            rand_ctl();
            tick();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc", pc, m_pc);
            chk("hold_instr", instr, word);
            chk("hold_ret", retired, m_ret);
        end
        Branch = br;
        Jump   = jmp;
        Zero   = z;
        pcW    = 1'b1;
        tick();
        pcW  = 1'b0;
        m_pc  = model_next(m_pc, word, br, jmp, z);
        m_ret = m_ret + 32'd1;
        chk("commit_pc", pc, m_pc);
        chk("retired", retired, m_ret);
        chk("commit_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = $urandom;
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0; pcW = 1'b0;
        m_pc = c_RESET_PC; m_ret = 32'd0;
        tick();
        tick();
        chk("rst_pc", pc, c_RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        rst = 1'b0; imem_ready = 1'b0;
        tick();

        run_instr(32'h8C22_0004, 0, 0, 0, 0, 0);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0);
        run_instr(32'h0000_0022, 0, 0, 0, 0, 0);
        chk("ret_three", retired, 32'd3);
        run_instr(32'h0000_0025, 3, 2, 0, 0, 0);
        run_instr(32'h1000_FFFE, 0, 0, 1, 0, 1);
        chk("beq_taken", imem_addr, 32'h0000_300C);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0);
        run_instr(32'h1000_FFFE, 0, 0, 1, 0, 0);
        chk("beq_not", imem_addr, 32'h0000_3014);
        run_instr(32'h0800_0C08, 1, 0, 0, 1, 0);
        run_instr(32'h0800_0C10, 0, 1, 0, 1, 0);
        chk("jump", imem_addr, 32'h0000_3040);
        run_instr(32'h0800_0C10, 0, 0, 1, 1, 1);
        chk("jump_wins", imem_addr, 32'h0000_3040);
        run_instr(32'h1000_8000, 0, 0, 1, 0, 1);
        chk("br_wrap", imem_addr, 32'hFFFE_3044);
        run_instr(32'h0BFF_FFFF, 0, 0, 0, 1, 0);
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0);
        chk("pc_wrap", imem_addr, 32'h0000_0000);

        for (int n = 0; n < 40; n++) begin
            run_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        imem_ready = 1'b1; imem_rdata = $urandom | 32'h1; rst = 1'b1;
        tick();
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_pc", pc, c_RESET_PC);
        chk("midrst_ret", retired, 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
        rst = 1'b0; imem_ready = 1'b0;
        m_pc = c_RESET_PC; m_ret = 32'd0;
        tick();
        for (int n = 0; n < 10; n++) begin
            run_instr($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the single-cycle control unit. Holds the PC and drives a request/ready handshake to instruction memory. Latches the returned word into an instruction register and presents op/func and the other fields to decode. Computes the next PC from the Branch/Jump/Zero/pcW signals fed back from control and the ALU.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  word-aligned fetch address (= pc)
imem_ready  in  1  memory has valid data on imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
Branch  in  1  from control: current instruction is beq
Jump  in  1  from control: current instruction is j
Zero  in  1  from ALU: comparison result equal
pcW  in  1  from control: commit current instruction, advance PC
instr  out  32  instruction register
op  out  6  instr[31:26]
func  out  6  instr[5:0]
rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
imm16  out  16  instr[15:0]
instr_valid  out  1  instr holds a fetched, uncommitted instruction
pc  out  32  address of instruction in instr
pc_plus4  out  32  pc + 4
retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-fetch): pc=RESET_PC, instr=0, instr_valid=0, retired=0, state=IDLE, imem_req=0. Any imem_ready arriving while rst=1 is ignored.
- FSM states: IDLE, FETCH, EXEC.
- IDLE: imem_req=0. Next state is FETCH unconditionally, one cycle after reset deasserts.
- FETCH: imem_req=1, imem_addr=pc, held stable until ready.
  - If imem_ready=1: instr<=imem_rdata, instr_valid<=1, next state EXEC.
  - If imem_ready=0: stay in FETCH; pc and instr are unchanged.
  - imem_ready is sampled only in FETCH.
- EXEC: imem_req=0, instr_valid=1. Branch, Jump, Zero and pcW are sampled only in EXEC.
  - If pcW=1: pc<=next_pc, retired<=retired+1 (wraps modulo 2^CNT_W), instr_valid<=0, next state FETCH.
  - If pcW=0: hold everything.
- next_pc, evaluated in priority order:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch=1 and Zero=1: pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - Otherwise: pc_plus4.
  - Jump and Branch both 1 is illegal from control; Jump wins.
- Arithmetic: all PC adds are 32-bit modulo 2^32. 0xFFFF_FFFC + 4 wraps to 0. A negative branch offset below 0 wraps.
- Field outputs are combinational slices of instr. They are valid whenever instr_valid=1 and undefined-but-stable otherwise.
- pc_plus4 is combinational from pc.
- Latency:
  - Minimum 1 cycle per fetch (imem_ready already high on the first FETCH cycle) plus 1 EXEC cycle, so 2 cycles per instruction.
  - First instr_valid occurs 2 cycles after rst deasserts when memory is zero-wait.
- pc[1:0] is always 00; no misalignment can occur.

Test Plan:
- Reset with RESET_PC=0x3000: release rst -> cycle 1 imem_req=1, imem_addr=0x3000; imem_ready=1, rdata=0x8C220004 -> next cycle instr_valid=1, op=0x23, rs=1, rt=2, imm16=4.
- Sequential flow: zero-wait memory, pcW=1 every EXEC -> addresses 0x3000, 0x3004, 0x3008; retired=3 after three commits.
- Taken beq at pc=0x3010, imm16=0xFFFE, Branch=1, Zero=1, pcW=1 -> next imem_addr=0x300C. Same with Zero=0 -> 0x3014.
- Jump at pc=0x3020, instr=0x08000C10, Jump=1 -> next imem_addr=0x00003040. Jump=1 and Branch=1 together -> still 0x00003040.
- Wait states: imem_ready low 3 cycles -> imem_req held, imem_addr stable, instr_valid=0. pcW=0 for 2 EXEC cycles -> pc, instr and retired unchanged.
- Reset mid-FETCH with imem_ready=1 in the same cycle -> instr stays 0, instr_valid=0, pc=RESET_PC. Wrap case: pc=0xFFFFFFFC with pcW -> pc=0.
